// File: rtl/if_fetch_ctrl_if.sv
// Control bundle between the IF sequencer, the hazard/ID branch logic and the IF datapath.
// The hazard unit and ID drive the inputs; the sequencer drives the datapath enables.
interface if_fetch_ctrl_if;
   logic        hazard_stall;
   logic        branch_taken;
   logic        target_alu;
   logic        annul_delay;
   logic        dp_rst;
   logic        pc_le;
   logic        npc_le;
   logic        ifid_le;
   logic        ifid_clear;
   logic [1:0]  mux_sel;
   logic        fetch_valid;
   logic [15:0] stall_cycles;

   modport master (
      output hazard_stall, branch_taken, target_alu, annul_delay,
      input  dp_rst, pc_le, npc_le, ifid_le, ifid_clear, mux_sel, fetch_valid, stall_cycles
   );

   modport slave (
      input  hazard_stall, branch_taken, target_alu, annul_delay,
      output dp_rst, pc_le, npc_le, ifid_le, ifid_clear, mux_sel, fetch_valid, stall_cycles
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// IF stage sequencer: reset hold, imem wait states, load-use stalls and delayed-branch
// redirect with delay-slot annul.
module if_fetch_ctrl #(
   parameter int unsigned RST_HOLD  = 2,
   parameter int unsigned IMEM_WAIT = 0
) (
   input logic           clk,
   input logic           R,
   if_fetch_ctrl_if.slave bus
);

   localparam int unsigned HoldW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HoldW-1:0] HoldInit = HoldW'(RST_HOLD - 1);
   localparam logic [3:0]       WaitInit = 4'(IMEM_WAIT);

   localparam logic [1:0] StRst   = 2'd0;
   localparam logic [1:0] StHold  = 2'd1;
   localparam logic [1:0] StFetch = 2'd2;
   localparam logic [1:0] StWait  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]       wait_cnt_q, wait_cnt_d;
   logic             pend_q, pend_d;
   logic             p_alu_q, p_alu_d;
   logic             p_annul_q, p_annul_d;
   logic [15:0]      stall_cnt_q, stall_cnt_d;

   logic stall;
   logic redirect;
   logic sel_alu;
   logic clr;

   assign stall = bus.hazard_stall;

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      pend_d      = pend_q;
      p_alu_d     = p_alu_q;
      p_annul_d   = p_annul_q;
      stall_cnt_d = stall_cnt_q;

      bus.dp_rst      = 1'b0;
      bus.pc_le       = 1'b0;
      bus.npc_le      = 1'b0;
      bus.ifid_le     = 1'b0;
      bus.ifid_clear  = 1'b0;
      bus.mux_sel     = 2'b00;
      bus.fetch_valid = 1'b0;

      redirect = 1'b0;
      sel_alu  = 1'b0;
      clr      = 1'b0;

      case (state_q)
         StRst: begin
            bus.dp_rst     = 1'b1;
            bus.ifid_clear = 1'b1;
            state_d        = StHold;
            hold_cnt_d     = HoldInit;
         end
         StHold: begin
            bus.dp_rst     = 1'b1;
            bus.ifid_clear = 1'b1;
            if (hold_cnt_q == '0) state_d = StFetch;
            else                  hold_cnt_d = hold_cnt_q - HoldW'(1);
         end
         StFetch: begin
            if (!stall) begin
               // A branch captured during a wait state takes precedence over one in ID now.
               redirect        = pend_q | bus.branch_taken;
               sel_alu         = pend_q ? p_alu_q : bus.target_alu;
               clr             = pend_q ? p_annul_q : (bus.branch_taken & bus.annul_delay);
               bus.pc_le       = 1'b1;
               bus.npc_le      = 1'b1;
               bus.ifid_le     = 1'b1;
               bus.ifid_clear  = clr;
               bus.fetch_valid = ~clr;
               if (redirect) bus.mux_sel = sel_alu ? 2'b01 : 2'b10;
               pend_d = 1'b0;
               if (IMEM_WAIT != 0) begin
                  state_d    = StWait;
                  wait_cnt_d = WaitInit;
               end
            end
         end
         StWait: begin
            if (!stall) begin
               bus.ifid_clear = 1'b1;
               if (bus.branch_taken) begin
                  pend_d    = 1'b1;
                  p_alu_d   = bus.target_alu;
                  p_annul_d = bus.annul_delay;
               end
            end
            // The memory wait runs down regardless of a stall.
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) state_d = StFetch;
         end
         default: state_d = StRst;
      endcase

      if ((state_q == StFetch || state_q == StWait) && stall && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cycles = stall_cnt_q;

   always_ff @(posedge clk or negedge R) begin
      if (!R) begin
         state_q     <= StRst;
         hold_cnt_q  <= '0;
         wait_cnt_q  <= '0;
         pend_q      <= 1'b0;
         p_alu_q     <= 1'b0;
         p_annul_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         pend_q      <= pend_d;
         p_alu_q     <= p_alu_d;
         p_annul_q   <= p_annul_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: one instance with no imem wait, one with two wait
// states; the driver queues expected outputs, a negedge monitor pops and compares.
module tb_if_fetch_ctrl;

   // {dp_rst, pc_le, npc_le, ifid_le, ifid_clear, mux_sel[1:0], fetch_valid}
   localparam logic [7:0] ExpRst      = 8'b1000_1000;
   localparam logic [7:0] ExpFetch    = 8'b0111_0001;
   localparam logic [7:0] ExpStall    = 8'b0000_0000;
   localparam logic [7:0] ExpBubble   = 8'b0000_1000;
   localparam logic [7:0] ExpTaAnnul  = 8'b0111_1100;
   localparam logic [7:0] ExpTaKeep   = 8'b0111_0101;
   localparam logic [7:0] ExpAluKeep  = 8'b0111_0011;
   localparam logic [7:0] ExpAluAnnul = 8'b0111_1010;

   typedef struct {
      bit          dut;
      logic [7:0]  o;
      bit          chk_sc;
      logic [15:0] sc;
      string       name;
   } exp_t;

   logic clk;
   logic r0, r2;
   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   if_fetch_ctrl_if f0 ();
   if_fetch_ctrl_if f2 ();

   if_fetch_ctrl #(.RST_HOLD(2), .IMEM_WAIT(0)) u_dut0 (.clk(clk), .R(r0), .bus(f0.slave));
   if_fetch_ctrl #(.RST_HOLD(2), .IMEM_WAIT(2)) u_dut2 (.clk(clk), .R(r2), .bus(f2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input bit d, input logic r, input logic hs, input logic bt,
                       input logic ta, input logic ad, input logic [7:0] e, input string nm,
                       input bit csc = 0, input logic [15:0] sc = 16'd0, input bit chk = 1);
      exp_t x;
      if (d == 0) begin
         r0 = r; f0.hazard_stall = hs; f0.branch_taken = bt;
         f0.target_alu = ta; f0.annul_delay = ad;
      end else begin
         r2 = r; f2.hazard_stall = hs; f2.branch_taken = bt;
         f2.target_alu = ta; f2.annul_delay = ad;
      end
      if (chk) begin
         x.dut = d; x.o = e; x.chk_sc = csc; x.sc = sc; x.name = nm;
         q.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [7:0]  act;
      logic [15:0] act_sc;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.dut == 0) begin
            act    = {f0.dp_rst, f0.pc_le, f0.npc_le, f0.ifid_le, f0.ifid_clear,
                      f0.mux_sel, f0.fetch_valid};
            act_sc = f0.stall_cycles;
         end else begin
            act    = {f2.dp_rst, f2.pc_le, f2.npc_le, f2.ifid_le, f2.ifid_clear,
                      f2.mux_sel, f2.fetch_valid};
            act_sc = f2.stall_cycles;
         end
         n_chk++;
         if (act !== e.o) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected %b", e.name, act, e.o);
         end
         if (e.chk_sc) begin
            n_chk++;
            if (act_sc !== e.sc) begin
               n_fail++;
               $display("FAIL %s: stall_cycles got %h expected %h", e.name, act_sc, e.sc);
            end
         end
      end
   end

   initial begin
      r0 = 1'b1; r2 = 1'b1;
      f0.hazard_stall = 0; f0.branch_taken = 0; f0.target_alu = 0; f0.annul_delay = 0;
      f2.hazard_stall = 0; f2.branch_taken = 0; f2.target_alu = 0; f2.annul_delay = 0;
      #2;
      r0 = 1'b0; r2 = 1'b0;
      @(posedge clk);
      #1;

      // Reset low three cycles, then a two-cycle hold after release.
      repeat (3) step(0, 0, 0, 0, 0, 0, ExpRst, "rst_low");
      step(0, 1, 0, 0, 0, 0, ExpRst, "rel_edge1");
      step(0, 1, 0, 0, 0, 0, ExpRst, "rel_edge2");
      step(0, 1, 0, 0, 0, 0, ExpRst, "rel_edge3");
      step(0, 1, 0, 0, 0, 0, ExpFetch, "first_fetch", 1, 16'd0);

      // Taken branch to TA with annulled delay slot, then straight-line fetch.
      step(0, 1, 0, 1, 0, 1, ExpTaAnnul, "br_ta_annul");
      step(0, 1, 0, 0, 0, 0, ExpFetch, "after_br");
      step(0, 1, 0, 1, 1, 0, ExpAluKeep, "br_alu");

      // Stall dominates a presented branch; branch applies once the stall drops.
      step(0, 1, 1, 1, 0, 0, ExpStall, "stall1");
      step(0, 1, 1, 1, 0, 0, ExpStall, "stall2");
      step(0, 1, 0, 1, 0, 0, ExpTaKeep, "stall_release", 1, 16'd2);

      // Long stall saturates the counter.
      repeat (70000) step(0, 1, 1, 0, 0, 0, ExpStall, "", 0, 16'd0, 0);
      step(0, 1, 1, 0, 0, 0, ExpStall, "stall_sat_in", 1, 16'hFFFF);
      step(0, 1, 0, 0, 0, 0, ExpFetch, "stall_sat", 1, 16'hFFFF);

      // Two-wait-state instance.
      step(1, 1, 0, 0, 0, 0, ExpRst, "d2_rel");
      step(1, 1, 0, 0, 0, 0, ExpRst, "d2_hold1");
      step(1, 1, 0, 0, 0, 0, ExpRst, "d2_hold2");
      step(1, 1, 0, 0, 0, 0, ExpFetch, "d2_fetch1");
      step(1, 1, 0, 1, 1, 1, ExpBubble, "d2_wait_br");
      step(1, 1, 0, 0, 0, 0, ExpBubble, "d2_wait2");
      step(1, 1, 0, 1, 0, 0, ExpAluAnnul, "d2_pend_apply");
      step(1, 1, 0, 0, 0, 0, ExpBubble, "d2_wait3");
      step(1, 1, 0, 0, 0, 0, ExpBubble, "d2_wait4");
      step(1, 1, 0, 0, 0, 0, ExpFetch, "d2_pend_cleared");

      // Stall during the wait states does not hold back the wait countdown.
      step(1, 1, 1, 0, 0, 0, ExpStall, "d2_wstall1");
      step(1, 1, 1, 0, 0, 0, ExpStall, "d2_wstall2");
      step(1, 1, 0, 0, 0, 0, ExpFetch, "d2_after_wstall", 1, 16'd2);

      // Reset with a pending branch: pending redirect must be dropped.
      step(1, 1, 0, 1, 1, 0, ExpBubble, "d2_pend_set");
      step(1, 0, 0, 0, 0, 0, ExpRst, "d2_rst_mid_wait", 1, 16'd0);
      step(1, 1, 0, 0, 0, 0, ExpRst, "d2_rel2");
      step(1, 1, 0, 0, 0, 0, ExpRst, "d2_hold3");
      step(1, 1, 0, 0, 0, 0, ExpRst, "d2_hold4");
      step(1, 1, 0, 0, 0, 0, ExpFetch, "d2_post_rst_fetch", 1, 16'd0);

      @(negedge clk);
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: queue holds %0d expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
